// File: rtl/heap_pq_unit.sv
// Binary-heap priority queue (min or max). Supports PEEK/PUSH/POP/REPLACE and sifts one level per cycle.
// The optional flush input is compiled in when HEAP_PQ_FLUSH_EN is defined.
module heap_pq_unit #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int MAX_HEAP = 0,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_v,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_data,
`ifdef HEAP_PQ_FLUSH_EN
    input  logic              flush,
`endif
    output logic              out_v,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = CNT_W + 1;
    localparam logic [1:0] OP_PEEK = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_REPL = 2'd3;

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d, cur_q, cur_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   heap_q [DEPTH];
    logic [DATA_W-1:0]   heap_d [DEPTH];
    logic                out_v_q, out_v_d, out_err_q, out_err_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                flush_go, accept;
    logic [IW-1:0]       lc, rc;
    logic                lc_ok, rc_ok;
    logic [AW-1:0]       cur_a, par_a, best_a;

    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (MAX_HEAP != 0) ? (a > b) : (a < b);
    endfunction

`ifdef HEAP_PQ_FLUSH_EN
    assign flush_go = flush && (state_q == IDLE);
`else
    assign flush_go = 1'b0;
`endif

    assign in_ready = (state_q == IDLE) && !flush_go;
    assign accept   = in_v && in_ready;

    // Child/parent indices of the current sift position; children beyond count are ignored.
    assign cur_a  = AW'(cur_q);
    assign par_a  = AW'((cur_q - CNT_W'(1)) >> 1);
    assign lc     = ({1'b0, cur_q} << 1) + IW'(1);
    assign rc     = lc + IW'(1);
    assign lc_ok  = lc < {1'b0, count_q};
    assign rc_ok  = rc < {1'b0, count_q};
    assign best_a = (rc_ok && better(heap_q[AW'(rc)], heap_q[AW'(lc)])) ? AW'(rc) : AW'(lc);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_d      = cur_q;
        result_d   = result_q;
        heap_d     = heap_q;
        out_v_d    = 1'b0;
        out_err_d  = out_err_q;
        out_rd_d   = out_rd_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (flush_go) begin
                    count_d = '0;
                end else if (accept) begin
                    out_rd_d = in_rd;
                    case (in_op)
                        OP_PEEK: begin
                            out_v_d    = 1'b1;
                            out_err_d  = empty;
                            out_data_d = empty ? '0 : heap_q[0];
                        end
                        OP_PUSH: begin
                            if (full) begin
                                out_v_d    = 1'b1;
                                out_err_d  = 1'b1;
                                out_data_d = '0;
                            end else begin
                                heap_d[AW'(count_q)] = in_data;
                                count_d = count_q + CNT_W'(1);
                                cur_d   = count_q;
                                state_d = SIFT_UP;
                            end
                        end
                        default: begin
                            if (empty) begin
                                out_v_d    = 1'b1;
                                out_err_d  = 1'b1;
                                out_data_d = '0;
                            end else begin
                                result_d = heap_q[0];
                                cur_d    = '0;
                                state_d  = SIFT_DOWN;
                                if (in_op == OP_POP) begin
                                    heap_d[0] = heap_q[AW'(count_q - CNT_W'(1))];
                                    count_d   = count_q - CNT_W'(1);
                                end else begin
                                    heap_d[0] = in_data;
                                end
                            end
                        end
                    endcase
                end
            end
            SIFT_UP: begin
                if (cur_q == '0 || !better(heap_q[cur_a], heap_q[par_a])) begin
                    state_d    = IDLE;
                    out_v_d    = 1'b1;
                    out_err_d  = 1'b0;
                    out_data_d = '0;
                end else begin
                    heap_d[cur_a] = heap_q[par_a];
                    heap_d[par_a] = heap_q[cur_a];
                    cur_d         = CNT_W'(par_a);
                end
            end
            SIFT_DOWN: begin
                if (lc_ok && better(heap_q[best_a], heap_q[cur_a])) begin
                    heap_d[cur_a]  = heap_q[best_a];
                    heap_d[best_a] = heap_q[cur_a];
                    cur_d          = CNT_W'(best_a);
                end else begin
                    state_d    = IDLE;
                    out_v_d    = 1'b1;
                    out_err_d  = 1'b0;
                    out_data_d = result_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cur_q      <= '0;
            result_q   <= '0;
            out_v_q    <= 1'b0;
            out_err_q  <= 1'b0;
            out_rd_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            result_q   <= result_d;
            out_v_q    <= out_v_d;
            out_err_q  <= out_err_d;
            out_rd_q   <= out_rd_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage carries no reset; contents are meaningless beyond count.
    always_ff @(posedge clk) begin
        heap_q <= heap_d;
    end

    assign out_v    = out_v_q;
    assign out_err  = out_err_q;
    assign out_rd   = out_rd_q;
    assign out_data = out_data_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule
